// File: rtl/kij_sequencer.sv
// rtl/kij_sequencer.sv - kij-loop instruction sequencer driving core inst/xw_mode; KIJ_SEQ_TIMEOUT_EN adds an OFIFO stall timeout with err
module kij_sequencer #(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int act_rows = 8,
  parameter int len_kij  = 9,
  parameter int gap_cyc  = 10,
  parameter int w_base   = 1024
`ifdef KIJ_SEQ_TIMEOUT_EN
  ,
  parameter int timeout_cyc = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        xw_mode,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
`ifdef KIJ_SEQ_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_PE_LOAD, S_GAP, S_X_L0, S_EXEC, S_DRAIN, S_OFIFO_RD, S_NEXT, S_DONE
  } state_t;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam int B_CEN_P  = 32;
  localparam int B_WEN_P  = 31;
  localparam int B_CEN_X  = 19;
  localparam int B_OF_RD  = 6;
  localparam int B_L0_RD  = 3;
  localparam int B_L0_WR  = 2;
  localparam int B_EXEC   = 1;
  localparam int B_LOAD   = 0;

  localparam logic [15:0] W_LAST   = 16'(col - 1);
  localparam logic [15:0] GAP_LAST = 16'(gap_cyc - 1);
  localparam logic [15:0] ACT_LAST = 16'(act_rows - 1);
  localparam logic [15:0] DR_LAST  = 16'(col + row - 1);
  localparam logic [15:0] RD_CNT   = 16'(act_rows);
  localparam logic [3:0]  KIJ_LAST = 4'(len_kij - 1);

  state_t      state;
  logic [15:0] t;
  logic [3:0]  kij;

  logic [15:0] t_nxt;
  logic [15:0] rd_idx;
  logic [3:0]  kij_first;
  logic        rd_step;
  logic [10:0] a_w_cont;
  logic [10:0] a_w_first;
  logic [10:0] a_x_cont;
  logic [10:0] a_p;

`ifdef KIJ_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_CYC = 16'(timeout_cyc);
  logic [15:0] stall_cnt;
  logic [15:0] stall_base;
`endif

  // Address and step helpers; in OFIFO_RD, t counts transfers already issued
  always_comb begin
    t_nxt     = t + 16'd1;
    kij_first = (state == S_NEXT) ? kij + 4'd1 : 4'd0;
    rd_idx    = (state == S_OFIFO_RD) ? t : 16'd0;
    rd_step   = ((state == S_DRAIN) && (t == DR_LAST)) ||
                ((state == S_OFIFO_RD) && (t != RD_CNT));
    a_w_cont  = 11'(w_base + int'(kij) * col + int'(t_nxt));
    a_w_first = 11'(w_base + int'(kij_first) * col);
    a_x_cont  = t_nxt[10:0];
    a_p       = 11'(int'(kij) * act_rows + int'(rd_idx));
`ifdef KIJ_SEQ_TIMEOUT_EN
    stall_base = (state == S_OFIFO_RD) ? stall_cnt : 16'd0;
`endif
  end

  // Sequencer FSM; outputs are registered for the cycle being entered
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      t       <= 16'd0;
      kij     <= 4'd0;
      inst    <= IDLE_INST;
      xw_mode <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      kij_idx <= 4'd0;
`ifdef KIJ_SEQ_TIMEOUT_EN
      stall_cnt <= 16'd0;
      err       <= 1'b0;
`endif
    end else begin
      inst    <= IDLE_INST;
      xw_mode <= 1'b0;
      done    <= 1'b0;
`ifdef KIJ_SEQ_TIMEOUT_EN
      err     <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_W_L0;
            t                <= 16'd0;
            kij              <= 4'd0;
            kij_idx          <= 4'd0;
            busy             <= 1'b1;
            xw_mode          <= 1'b1;
            inst[B_L0_WR]    <= 1'b1;
            inst[B_CEN_X]    <= 1'b0;
            inst[17:7]       <= a_w_first;
          end
        end
        S_W_L0: begin
          xw_mode <= 1'b1;
          if (t == W_LAST) begin
            state         <= S_PE_LOAD;
            t             <= 16'd0;
            inst[B_L0_RD] <= 1'b1;
            inst[B_LOAD]  <= 1'b1;
          end else begin
            t             <= t_nxt;
            inst[B_L0_WR] <= 1'b1;
            inst[B_CEN_X] <= 1'b0;
            inst[17:7]    <= a_w_cont;
          end
        end
        S_PE_LOAD: begin
          if (t == W_LAST) begin
            state <= S_GAP;
            t     <= 16'd0;
          end else begin
            t             <= t_nxt;
            xw_mode       <= 1'b1;
            inst[B_L0_RD] <= 1'b1;
            inst[B_LOAD]  <= 1'b1;
          end
        end
        S_GAP: begin
          if (t == GAP_LAST) begin
            state         <= S_X_L0;
            t             <= 16'd0;
            inst[B_L0_WR] <= 1'b1;
            inst[B_CEN_X] <= 1'b0;
            inst[17:7]    <= 11'd0;
          end else begin
            t <= t_nxt;
          end
        end
        S_X_L0: begin
          if (t == ACT_LAST) begin
            state         <= S_EXEC;
            t             <= 16'd0;
            inst[B_EXEC]  <= 1'b1;
            inst[B_L0_RD] <= 1'b1;
          end else begin
            t             <= t_nxt;
            inst[B_L0_WR] <= 1'b1;
            inst[B_CEN_X] <= 1'b0;
            inst[17:7]    <= a_x_cont;
          end
        end
        S_EXEC: begin
          if (t == ACT_LAST) begin
            state <= S_DRAIN;
            t     <= 16'd0;
          end else begin
            t             <= t_nxt;
            inst[B_EXEC]  <= 1'b1;
            inst[B_L0_RD] <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (t != DR_LAST) t <= t_nxt;
        end
        S_OFIFO_RD: begin
          if (t == RD_CNT) begin
            state <= S_NEXT;
            t     <= 16'd0;
          end
        end
        S_NEXT: begin
          t <= 16'd0;
          if (kij == KIJ_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state         <= S_W_L0;
            kij           <= kij + 4'd1;
            kij_idx       <= kij + 4'd1;
            xw_mode       <= 1'b1;
            inst[B_L0_WR] <= 1'b1;
            inst[B_CEN_X] <= 1'b0;
            inst[17:7]    <= a_w_first;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          t       <= 16'd0;
          kij     <= 4'd0;
          kij_idx <= 4'd0;
        end
        default: state <= S_IDLE;
      endcase

      // OFIFO->pmem copy: a transfer is issued only when ofifo_valid was seen
      if (rd_step) begin
        state <= S_OFIFO_RD;
        if (ofifo_valid) begin
          t              <= rd_idx + 16'd1;
          inst[B_OF_RD]  <= 1'b1;
          inst[B_CEN_P]  <= 1'b0;
          inst[B_WEN_P]  <= 1'b0;
          inst[30:20]    <= a_p;
`ifdef KIJ_SEQ_TIMEOUT_EN
          stall_cnt      <= 16'd0;
`endif
        end else begin
          t <= rd_idx;
`ifdef KIJ_SEQ_TIMEOUT_EN
          if (stall_base == TO_CYC) begin
            state     <= S_IDLE;
            t         <= 16'd0;
            kij       <= 4'd0;
            kij_idx   <= 4'd0;
            busy      <= 1'b0;
            err       <= 1'b1;
            stall_cnt <= 16'd0;
          end else begin
            stall_cnt <= stall_base + 16'd1;
          end
`endif
        end
      end
    end
  end

endmodule
